adder_arb: RTL and testbench

ADDER_ARB -- requirements
Module: adder_arb

---
 rtl/adder_arb.sv | 118 +++++++++++
 tb/tb_adder_arb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/adder_arb.sv
// adder_arb: two-requester credit-checked arbiter in front of a shared pipelined adder, with per-requester result FIFOs.
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties) instead of round-robin.
`ifndef LEN_DATA
`define LEN_DATA 32
`endif
module adder_arb #(
  parameter int ADD_LAT = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [`LEN_DATA-1:0] req0_a,
  input  logic [`LEN_DATA-1:0] req0_b,
  input  logic                 req0_cin,
  input  logic                 req0_sub,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [`LEN_DATA-1:0] req1_a,
  input  logic [`LEN_DATA-1:0] req1_b,
  input  logic                 req1_cin,
  input  logic                 req1_sub,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic [`LEN_DATA-1:0] rsp0_sum,
  output logic                 rsp0_cout,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [`LEN_DATA-1:0] rsp1_sum,
  output logic                 rsp1_cout,
  output logic                 add_valid,
  output logic [`LEN_DATA-1:0] add_a,
  output logic [`LEN_DATA-1:0] add_b,
  output logic                 add_cin,
  input  logic [`LEN_DATA-1:0] add_sum,
  input  logic                 add_cout,
  output logic                 busy
);
  localparam int W = `LEN_DATA;
  logic [1:0] rv, rc, rs, rr, elig, g, push, pop, nz;
  logic [W-1:0] ra [2];
  logic [W-1:0] rb [2];
  logic [ADD_LAT-1:0] tv, tid;
  logic [3:0] infl [2];
  logic [2:0] occ [2];
  logic [1:0] wp [2];
  logic [1:0] rp [2];
  logic [W:0] mem [2][4];
  logic gv, sel;
`ifndef ADDER_ARB_FIXED_PRIO_EN
  logic last;
`endif
  function automatic logic [1:0] nx(input logic [1:0] p);
    return p == 2'(BUF_DEPTH - 1) ? 2'd0 : p + 2'd1;
  endfunction
  assign rv = {req1_valid, req0_valid};
  assign rc = {req1_cin, req0_cin};
  assign rs = {req1_sub, req0_sub};
  assign rr = {rsp1_ready, rsp0_ready};
  assign ra = '{req0_a, req1_a};
  assign rb = '{req0_b, req1_b};
  assign infl[0] = 4'($countones(tv & ~tid));
  assign infl[1] = 4'($countones(tv & tid));
  // credit covers both in-flight tags and buffered results, so a FIFO can never overflow
  assign elig[0] = ~rst & rv[0] & (infl[0] + 4'(occ[0]) < 4'(BUF_DEPTH));
  assign elig[1] = ~rst & rv[1] & (infl[1] + 4'(occ[1]) < 4'(BUF_DEPTH));
`ifdef ADDER_ARB_FIXED_PRIO_EN
  assign g[0] = elig[0];
`else
  assign g[0] = elig[0] & (~elig[1] | last);
`endif
  assign g[1] = elig[1] & ~g[0];
  assign gv = |g;
  assign sel = g[1];
  assign req0_ready = g[0];
  assign req1_ready = g[1];
  assign add_valid = gv;
  assign add_a = gv ? ra[sel] : '0;
  assign add_b = gv ? (rs[sel] ? ~rb[sel] : rb[sel]) : '0;
  assign add_cin = gv & (rs[sel] | rc[sel]);
  assign push = {tv[ADD_LAT-1] & tid[ADD_LAT-1], tv[ADD_LAT-1] & ~tid[ADD_LAT-1]};
  assign nz = {occ[1] != 3'd0, occ[0] != 3'd0} & {2{~rst}};
  assign pop = nz & rr;
  assign rsp0_valid = nz[0];
  assign rsp1_valid = nz[1];
  assign {rsp0_cout, rsp0_sum} = mem[0][rp[0]];
  assign {rsp1_cout, rsp1_sum} = mem[1][rp[1]];
  assign busy = ~rst & ((|tv) | (|nz));
  always_ff @(posedge clk) begin
    if (rst) begin
      tv <= '0;
      tid <= '0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      last <= 1'b1;
`endif
      for (int n = 0; n < 2; n++) begin
        occ[n] <= '0;
        wp[n] <= '0;
        rp[n] <= '0;
      end
    end else begin
      tv <= (tv << 1) | ADD_LAT'(gv);
      tid <= (tid << 1) | ADD_LAT'(g[1]);
`ifndef ADDER_ARB_FIXED_PRIO_EN
      if (gv) last <= g[1];
`endif
      for (int n = 0; n < 2; n++) begin
        if (push[n]) begin
          mem[n][wp[n]] <= {add_cout, add_sum};
          wp[n] <= nx(wp[n]);
        end
        if (pop[n]) rp[n] <= nx(rp[n]);
        occ[n] <= occ[n] + 3'(push[n]) - 3'(pop[n]);
      end
    end
  end
endmodule

// File: tb/tb_adder_arb.sv
// tb_adder_arb: scoreboard bench for adder_arb driving a behavioural ADD_LAT-cycle adder model.
`ifndef LEN_DATA
`define LEN_DATA 32
`endif
module tb_adder_arb;
  localparam int LAT = 2;
  localparam int DEPTH = 2;
  localparam int W = `LEN_DATA;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_cin = 0, req1_cin = 0, req0_sub = 0, req1_sub = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout;
  logic rsp0_ready = 1, rsp1_ready = 1;
  logic [W-1:0] rsp0_sum, rsp1_sum, add_a, add_b, add_sum;
  logic add_valid, add_cin, add_cout, busy;
  logic [W:0] st [LAT];
  logic [W:0] exp0 [$];
  logic [W:0] exp1 [$];
  int gq [$];
  int errors = 0, checks = 0, cyc = 0, seen0 = 0;
  bit watch = 0;

  adder_arb #(.ADD_LAT(LAT), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_sub(req1_sub),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    st[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
    for (int i = 1; i < LAT; i++) st[i] <= st[i-1];
  end
  assign {add_cout, add_sum} = st[LAT-1];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (watch && rsp0_valid) seen0++;
      if (rsp0_valid && rsp0_ready) begin
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp0_spurious: got %0h want none", {rsp0_cout, rsp0_sum});
        end else check("rsp0", 64'({rsp0_cout, rsp0_sum}), 64'(exp0.pop_front()));
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp1_spurious: got %0h want none", {rsp1_cout, rsp1_sum});
        end else check("rsp1", 64'({rsp1_cout, rsp1_sum}), 64'(exp1.pop_front()));
      end
    end
  end

  task automatic drive(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic [W:0] e, output int acc);
    bit ok = 0;
    acc = -1;
    if (n == 0) begin req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_valid = 1; end
    else begin req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_valid = 1; end
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if (n == 0 ? req0_ready : req1_ready) begin
        ok = 1;
        acc = cyc;
        gq.push_back(n);
        if (n == 0) exp0.push_back(e); else exp1.push_back(e);
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req%0d_accept: got timeout want ready", n);
    end
    if (n == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic hold0(input string nm);
    for (int i = 0; i < 4; i++) begin
      #1 check(nm, 64'(req0_ready), 64'd0);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp0.size() != 0 || exp1.size() != 0 || busy); i++) @(negedge clk);
    check("drain", {61'd0, exp0.size() != 0, exp1.size() != 0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  initial begin
    int k;
    bit got;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    int want [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
`else
    int want [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {req1_ready, req0_ready}, 0);
    check("rst_valid", {add_valid, rsp1_valid, rsp0_valid}, 0);
    check("rst_busy", 64'(busy), 0);
    @(negedge clk);
    rst = 0; req0_valid = 0; req1_valid = 0;
    #1;
    check("post_rst", {busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 0);
    @(negedge clk);

    drive(0, 5, 3, 0, 0, 33'h0_00000008, k);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #2;
      if (rsp0_valid) got = 1; else @(negedge clk);
    end
    check("latency", 64'(cyc - k), 64'd3);
    @(negedge clk);

    drive(0, 7, 8, 1, 0, 33'h0_00000010, k);
    drive(1, 3, 5, 0, 1, 33'h0_FFFFFFFE, k);
    drive(1, 5, 3, 1, 1, 33'h1_00000002, k);
    drive(1, 32'hFFFF_FFFF, 1, 0, 0, 33'h1_00000000, k);
    drain();
    #1 check("idle_add", {add_valid, add_cin, add_a, add_b}, 0);
    @(negedge clk);

    gq.delete();
    fork
      begin int k0; for (int i = 0; i < 4; i++) drive(0, W'(100 + i), W'(i), 0, 0, (W+1)'(100 + 2*i), k0); end
      begin int k1; for (int i = 0; i < 4; i++) drive(1, W'(200 + i), 1, 1, 0, (W+1)'(202 + i), k1); end
    join
    drain();
    check("grant_count", 64'(gq.size()), 64'd8);
    for (int i = 0; i < 8 && i < gq.size(); i++) check($sformatf("grant%0d", i), 64'(gq[i]), 64'(want[i]));

    rsp0_ready = 0;
    drive(0, 1, 1, 0, 0, 33'h0_00000002, k);
    drive(0, 2, 2, 0, 0, 33'h0_00000004, k);
    req0_a = 3; req0_b = 3; req0_cin = 0; req0_sub = 0; req0_valid = 1;
    hold0("bp_full");
    rsp0_ready = 1;
    @(negedge clk);
    rsp0_ready = 0;
    drive(0, 3, 3, 0, 0, 33'h0_00000006, k);
    check("bp_third", 64'(k >= 0), 64'd1);
    req0_a = 4; req0_b = 4; req0_valid = 1;
    hold0("bp_refull");
    rsp0_ready = 1;
    drive(0, 4, 4, 0, 0, 33'h0_00000008, k);
    drain();

    drive(0, 9, 9, 0, 0, 33'h0_00000012, k);
    rst = 1;
    exp0.delete();
    watch = 1;
    #1 check("rst_mid_busy", {busy, rsp0_valid}, 0);
    @(negedge clk);
    rst = 0;
    #1 check("rst_after_busy", 64'(busy), 0);
    repeat (6) @(negedge clk);
    watch = 0;
    check("rst_discard", 64'(seen0), 0);

    gq.delete();
    fork
      drive(0, 10, 20, 0, 0, 33'h0_0000001E, k);
      begin int k2; drive(1, 40, 2, 0, 1, 33'h1_00000026, k2); end
    join
    drain();
    check("tie_after_rst", {32'(gq.size()), 16'(gq.size() > 0 ? gq[0] : 9), 16'(gq.size() > 1 ? gq[1] : 9)},
          {32'd2, 16'd0, 16'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
